uart_rx_word_packer: RTL and testbench
======================================

Name: uart_rx_word_packer

Overview:
- Receive-side stage feeding the FPGA_Bluetooth_connection host path.
- Deserialises the 8N1 UART stream from the Bluetooth module on fpga_rxd.
- Packs byte pairs into 16-bit words: first byte received goes in [15:8], second in [7:0]. Example: "AT" → 16'h4154, the same packing as the ep01wireIn command words.
- Presents each word on a valid/ready handshake toward the wireOut/FIFO logic, with sticky framing and overrun flags.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Minimum 4; simulation default is 16, build value is 5208 (50 MHz / 9600).
- SYNC_STAGES, 2: depth of the fpga_rxd synchroniser. Minimum 2.

Ports:
- clock  in  1  system clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- fpga_rxd  in  1  UART serial input; idle high.
- word_out  out  16  packed word {byte0, byte1}.
- word_valid  out  1  word_out holds an untransferred word.
- word_ready  in  1  consumer accepts the word when word_valid && word_ready.
- flush  in  1  single-cycle pulse; emits a pending half word.
- clear_errors  in  1  single-cycle pulse; clears the sticky flags.
- half_pending  out  1  one byte is held, waiting for its partner.
- framing_error  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a word was dropped because word_valid was still set.

Behaviour:
- Reset values: word_out = 0, word_valid = 0, half_pending = 0, framing_error = 0, overrun = 0, FSM = IDLE, all synchroniser flops = 1.
- Synchroniser: fpga_rxd passes through SYNC_STAGES flops; the result is rxs. All decisions use rxs only.
- Bit counter: cnt runs 0..CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when rxs = 0, go to START with cnt = 0.
- START: at cnt = CLKS_PER_BIT/2 - 1 (mid start bit), sample rxs.
  - rxs = 1: glitch, return to IDLE with no flag.
  - rxs = 0: go to DATA, cnt = 0, bit index = 0.
- DATA: sample rxs at cnt = CLKS_PER_BIT-1, i.e. mid-bit. Samples shift in LSB first. After bit 7, go to STOP.
- STOP: sample at mid stop bit.
  - rxs = 1: byte accepted, return to IDLE the same cycle. A new start can be detected on the next cycle.
  - rxs = 0: byte discarded, set framing_error, go to BREAK. half_pending is unchanged.
- BREAK: wait for rxs = 1, then go to IDLE. A held-low line yields exactly one framing_error and no bytes.
- Packing on an accepted byte:
  - half_pending = 0: store the byte in the high register and set half_pending.
  - half_pending = 1: form the word {high, byte} and clear half_pending.
- Word output: word_valid and word_out update on the clock edge following the stop-sample cycle (latency 1).
- Word completes while word_valid = 1 and no transfer happens that cycle:
  - word_out is kept (the old word).
  - The new word is dropped and overrun is set.
  - half_pending still clears.
- Transfer and completion in the same cycle: this is not an overrun. The new word loads and word_valid stays 1.
- word_valid and word_out hold while word_ready = 0. After a transfer with no new word, word_valid = 0 the next cycle.
- flush:
  - half_pending = 1 and word_valid = 0: emit {high, 8'h00}, clear half_pending.
  - word_valid = 1: flush is ignored and half_pending is kept.
  - half_pending = 0: no effect.
  - flush in the same cycle as a byte acceptance: the byte acceptance wins and flush is ignored.
- clear_errors clears both sticky flags. If a new error event occurs in the same cycle, that event wins and the flag stays set.
- resetn asserted mid-frame: everything returns to reset values immediately, including a partial byte, the half word and the flags. After release the FSM waits in IDLE for a fresh falling edge. A frame in progress is re-synchronised only through BREAK or IDLE behaviour.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP, BREAK};
  - the constants UART_DATA_BITS = 8 and UART_IDLE_LEVEL = 1'b1.
- One sub-module: uart_rx_core, covering the synchroniser, FSM and bit counter. It outputs rx_byte, rx_byte_valid (1-cycle pulse) and rx_frame_err (1-cycle pulse).
- The packer, handshake and sticky flags live in the top.

Test Plan (CLKS_PER_BIT = 16, word_ready = 1 unless stated):
- Send "A" then "T" back-to-back → one word_valid pulse with word_out = 16'h4154. half_pending is 1 between the two bytes, then 0.
- Send 0x0D, 0x0A with word_ready = 0, then send 0x4F, 0x4B → word_out stays 16'h0D0A and overrun = 1. Raise word_ready → 16'h0D0A transfers once and word_valid drops.
- Send 0x55 with the stop bit driven low → framing_error = 1, no word, half_pending = 0. Then pulse clear_errors → framing_error = 0.
- Drive a 5-cycle low glitch on fpga_rxd → no byte, no flags, FSM back in IDLE.
- Send 0x31, then pulse flush → word_out = 16'h3100, word_valid = 1, half_pending = 0.
- Assert resetn = 0 mid-way through byte 2 of "OK", release, then send "OK" → exactly one word, 16'h4F4B, and no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: frame FSM states and line constants.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uartState_e;

endpackage

// File: rtl/uart_rx_word_packer_if.sv
// Word handshake, control pulses and status flags between the packer and its consumer.
interface uart_rx_word_packer_if;

  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        flush;
  logic        clear_errors;
  logic        half_pending;
  logic        framing_error;
  logic        overrun;

  modport master (
    output word_out, word_valid, half_pending, framing_error, overrun,
    input  word_ready, flush, clear_errors
  );

  modport slave (
    input  word_out, word_valid, half_pending, framing_error, overrun,
    output word_ready, flush, clear_errors
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: input synchroniser, frame FSM and bit timing; emits one-cycle byte / framing pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      rx_byte_valid,
  output logic                      rx_frame_err
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]    syncChain_r;
  logic                      rxs_s;
  uartState_e                state_r;
  uartState_e                stateNext_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [2:0]                bitIdx_r;
  logic [UART_DATA_BITS-1:0] shift_r;
  logic                      stopSample_s;

  assign rxs_s = syncChain_r[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      syncChain_r <= {SYNC_STAGES{UART_IDLE_LEVEL}};
    end else begin
      syncChain_r <= {syncChain_r[SYNC_STAGES-2:0], rxd};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE: begin
        if (rxs_s != UART_IDLE_LEVEL) stateNext_s = START;
        else                          stateNext_s = IDLE;
      end
      START: begin
        // A start bit that is high again at its midpoint was only a glitch.
        if (cnt_r == CNT_MID) begin
          if (rxs_s == UART_IDLE_LEVEL) stateNext_s = IDLE;
          else                          stateNext_s = DATA;
        end else begin
          stateNext_s = START;
        end
      end
      DATA: begin
        if ((cnt_r == CNT_LAST) && (bitIdx_r == BIT_LAST)) stateNext_s = STOP;
        else                                               stateNext_s = DATA;
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          if (rxs_s == UART_IDLE_LEVEL) stateNext_s = IDLE;
          else                          stateNext_s = BREAK;
        end else begin
          stateNext_s = STOP;
        end
      end
      BREAK: begin
        if (rxs_s == UART_IDLE_LEVEL) stateNext_s = IDLE;
        else                          stateNext_s = BREAK;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  always_comb begin
    stopSample_s  = (state_r == STOP) && (cnt_r == CNT_LAST);
    rx_byte       = shift_r;
    rx_byte_valid = stopSample_s && (rxs_s == UART_IDLE_LEVEL);
    rx_frame_err  = stopSample_s && (rxs_s != UART_IDLE_LEVEL);
  end

  // After the half-bit START wait, each full-bit count ends at a bit midpoint.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_r    <= '0;
      bitIdx_r <= 3'd0;
      shift_r  <= '0;
    end else begin
      case (state_r)
        START: begin
          cnt_r    <= (cnt_r == CNT_MID) ? '0 : cnt_r + CNT_W'(1);
          bitIdx_r <= 3'd0;
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r    <= '0;
            shift_r  <= {rxs_s, shift_r[UART_DATA_BITS-1:1]};
            bitIdx_r <= bitIdx_r + 3'd1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          cnt_r <= (cnt_r == CNT_LAST) ? '0 : cnt_r + CNT_W'(1);
        end
        default: begin
          cnt_r    <= '0;
          bitIdx_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs received byte pairs into 16-bit words {first, second} behind a valid/ready handshake
// with sticky framing and overrun flags.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         fpga_rxd,
  uart_rx_word_packer_if.master        bus
);

  logic [UART_DATA_BITS-1:0] rxByte_s;
  logic                      rxByteValid_s;
  logic                      rxFrameErr_s;

  logic [7:0]  highByte_r, highNext_s;
  logic        halfPending_r, halfNext_s;
  logic [15:0] wordOut_r, wordNext_s;
  logic        wordValid_r, validNext_s;
  logic        framing_r, framingNext_s;
  logic        overrun_r, overrunNext_s;
  logic        complete_s;
  logic        transfer_s;
  logic        overrunEvent_s;
  logic [15:0] newWord_s;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_core (
    .clock         (clock),
    .resetn        (resetn),
    .rxd           (fpga_rxd),
    .rx_byte       (rxByte_s),
    .rx_byte_valid (rxByteValid_s),
    .rx_frame_err  (rxFrameErr_s)
  );

  // A byte acceptance outranks flush; flush only emits into an empty output slot.
  always_comb begin
    transfer_s  = wordValid_r && bus.word_ready;
    highNext_s  = highByte_r;
    halfNext_s  = halfPending_r;
    complete_s  = 1'b0;
    newWord_s   = 16'h0000;
    if (rxByteValid_s) begin
      if (halfPending_r) begin
        complete_s = 1'b1;
        newWord_s  = {highByte_r, rxByte_s};
        halfNext_s = 1'b0;
      end else begin
        highNext_s = rxByte_s;
        halfNext_s = 1'b1;
      end
    end else if (bus.flush && halfPending_r && !wordValid_r) begin
      complete_s = 1'b1;
      newWord_s  = {highByte_r, 8'h00};
      halfNext_s = 1'b0;
    end else begin
      complete_s = 1'b0;
    end
  end

  always_comb begin
    wordNext_s     = wordOut_r;
    validNext_s    = wordValid_r;
    overrunEvent_s = 1'b0;
    if (complete_s) begin
      if (!wordValid_r || transfer_s) begin
        wordNext_s  = newWord_s;
        validNext_s = 1'b1;
      end else begin
        overrunEvent_s = 1'b1;
      end
    end else if (transfer_s) begin
      validNext_s = 1'b0;
    end else begin
      validNext_s = wordValid_r;
    end
    // A fresh error in the clearing cycle keeps its flag set.
    framingNext_s = (framing_r && !bus.clear_errors) || rxFrameErr_s;
    overrunNext_s = (overrun_r && !bus.clear_errors) || overrunEvent_s;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      highByte_r    <= 8'h00;
      halfPending_r <= 1'b0;
      wordOut_r     <= 16'h0000;
      wordValid_r   <= 1'b0;
      framing_r     <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      highByte_r    <= highNext_s;
      halfPending_r <= halfNext_s;
      wordOut_r     <= wordNext_s;
      wordValid_r   <= validNext_s;
      framing_r     <= framingNext_s;
      overrun_r     <= overrunNext_s;
    end
  end

  assign bus.word_out      = wordOut_r;
  assign bus.word_valid    = wordValid_r;
  assign bus.half_pending  = halfPending_r;
  assign bus.framing_error = framing_r;
  assign bus.overrun       = overrun_r;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Randomised and directed bench for uart_rx_word_packer with a byte-pair reference model and word scoreboard.
module tb_uart_rx_word_packer;

  localparam int CPB = 16;

  logic clock    = 1'b0;
  logic resetn   = 1'b0;
  logic fpga_rxd = 1'b1;

  uart_rx_word_packer_if bus();

  uart_rx_word_packer #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .fpga_rxd (fpga_rxd),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] expQ[$];
  bit          randMode = 1'b0;

  // Reference model state: pairing of accepted bytes and expected sticky flags.
  bit          mHalf     = 1'b0;
  logic [7:0]  mHigh     = 8'h00;
  bit          mWaiting  = 1'b0;
  bit          mOverrun  = 1'b0;
  bit          mFrameErr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pushWord(input logic [15:0] w);
    if (mWaiting) begin
      mOverrun = 1'b1;
    end else begin
      expQ.push_back(w);
      mWaiting = !randMode && !bus.word_ready;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (randMode) bus.word_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit goodStop);
    if (goodStop) begin
      if (mHalf) begin
        pushWord({mHigh, b});
        mHalf = 1'b0;
      end else begin
        mHigh = b;
        mHalf = 1'b1;
      end
    end else begin
      mFrameErr = 1'b1;
    end
    fpga_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      fpga_rxd = b[i];
      tick(CPB);
    end
    fpga_rxd = goodStop;
    tick(CPB);
    fpga_rxd = 1'b1;
  endtask

  task automatic pulseClear();
    bus.clear_errors = 1'b1;
    tick(1);
    bus.clear_errors = 1'b0;
    mOverrun  = 1'b0;
    mFrameErr = 1'b0;
  endtask

  task automatic checkFlags(input string tag);
    check({tag, "_framing"}, bus.framing_error, mFrameErr);
    check({tag, "_overrun"}, bus.overrun, mOverrun);
    check({tag, "_half"}, bus.half_pending, mHalf);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected word.
  always @(negedge clock) begin
    if (resetn && bus.word_valid && bus.word_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %h expected none", bus.word_out);
      end else begin
        check("word", bus.word_out, expQ.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.word_ready   = 1'b1;
    bus.flush        = 1'b0;
    bus.clear_errors = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_word_out", bus.word_out, 16'h0000);
    check("rst_valid", bus.word_valid, 1'b0);
    checkFlags("rst");
    resetn = 1'b1;
    tick(5);

    // "AT" back to back
    sendFrame(8'h41, 1'b1);
    tick(2);
    check("at_half_mid", bus.half_pending, 1'b1);
    sendFrame(8'h54, 1'b1);
    tick(4);
    checkFlags("at");
    check("at_drained", expQ.size(), 0);

    // Overrun while the consumer stalls
    bus.word_ready = 1'b0;
    sendFrame(8'h0D, 1'b1);
    sendFrame(8'h0A, 1'b1);
    sendFrame(8'h4F, 1'b1);
    sendFrame(8'h4B, 1'b1);
    tick(4);
    check("ovr_word_out", bus.word_out, 16'h0D0A);
    check("ovr_valid", bus.word_valid, 1'b1);
    checkFlags("ovr");
    bus.word_ready = 1'b1;
    mWaiting = 1'b0;
    tick(1);
    check("ovr_valid_drop", bus.word_valid, 1'b0);
    check("ovr_drained", expQ.size(), 0);
    pulseClear();
    checkFlags("ovr_clr");

    // Stop bit low
    sendFrame(8'h55, 1'b0);
    tick(6);
    check("fe_valid", bus.word_valid, 1'b0);
    checkFlags("fe");
    pulseClear();
    checkFlags("fe_clr");

    // Five-cycle glitch
    fpga_rxd = 1'b0;
    tick(5);
    fpga_rxd = 1'b1;
    tick(40);
    check("glitch_valid", bus.word_valid, 1'b0);
    checkFlags("glitch");

    // Flush of a half word
    sendFrame(8'h31, 1'b1);
    tick(4);
    check("flush_half_before", bus.half_pending, 1'b1);
    bus.flush = 1'b1;
    pushWord({mHigh, 8'h00});
    mHalf = 1'b0;
    tick(1);
    bus.flush = 1'b0;
    check("flush_valid", bus.word_valid, 1'b1);
    check("flush_word_out", bus.word_out, 16'h3100);
    check("flush_half", bus.half_pending, 1'b0);
    tick(3);

    // Reset in the middle of the second byte of "OK"
    sendFrame(8'h4F, 1'b1);
    fpga_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      fpga_rxd = (8'h4B >> i) & 8'h01;
      tick(CPB);
    end
    resetn   = 1'b0;
    fpga_rxd = 1'b1;
    mHalf    = 1'b0;
    tick(3);
    check("mid_rst_valid", bus.word_valid, 1'b0);
    checkFlags("mid_rst");
    resetn = 1'b1;
    tick(20);
    sendFrame(8'h4F, 1'b1);
    sendFrame(8'h4B, 1'b1);
    tick(4);
    checkFlags("ok");
    check("ok_drained", expQ.size(), 0);

    // Random bytes, random gaps, random consumer stalls, occasional bad stop bits
    randMode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      sendFrame(b, !bad);
      tick(bad ? 6 + $urandom_range(0, 10) : $urandom_range(0, 30));
    end
    randMode       = 1'b0;
    bus.word_ready = 1'b1;
    tick(10);
    checkFlags("rand");
    check("rand_drained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
